// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Default first fetch address after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction field positions (MIPS encoding).
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int JIDX_MSB  = 25;

  // Sign-extend a 16-bit immediate to a 32-bit word.
  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for a retired instruction: jump, taken branch, or
// sequential. Purely combinational so the target arithmetic can be
// exercised on its own.
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0]              pcplus4;
  logic [31:0]              branch_off;
  logic [OP_MSB-JIDX_MSB-1:0] unused_op_bits;

  assign pcplus4    = pc + 32'd4;
  // Branch offset is a word offset; modulo-2^32 add wraps silently.
  assign branch_off = sign_ext16(instr[IMM_MSB:0]) << 2;

  // The opcode field does not take part in target computation.
  assign unused_op_bits = instr[OP_MSB:JIDX_MSB+1];

  // Select target: jump has priority over a taken branch.
  always_comb begin
    next_pc = pcplus4;
    if (jump) begin
      next_pc = {pcplus4[31:28], instr[JIDX_MSB:0], 2'b00};
    end else if (pcsrc) begin
      next_pc = pcplus4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and instruction register, fetches
// from instruction memory over a req/ack handshake and hands the latched
// instruction to the controller/datapath until it is retired.
// Optional build macro: FETCH_PERFCNT_EN adds retired_cnt / stall_cnt.
//
// Memory handshake: imem_req is high exactly while in FETCH; imem_addr is
// held at the PC and does not change while imem_req is high. A transfer
// completes on any rising edge where imem_req and imem_ack are both high
// (ack may come in the same cycle as the request). imem_ack with imem_req
// low is ignored. Downstream handshake: instr_valid is high while an
// instruction is held; a cycle with instr_valid and retire both high
// consumes it, and pcsrc/jump are only looked at in that cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_ack,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] pcplus4,
  output logic             instr_valid,
  input  logic             retire,
  input  logic             pcsrc,
  input  logic             jump,
`ifdef FETCH_PERFCNT_EN
  output logic [31:0]      retired_cnt,
  output logic [31:0]      stall_cnt,
`endif
  output fetch_state_e     dbg_state
);

  // PC is always word aligned, including the reset value.
  localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] next_pc;

  // Target computation for the instruction currently held.
  pc_next u_pc_next (
    .pc      (pc_q),
    .instr   (instr_q),
    .pcsrc   (pcsrc),
    .jump    (jump),
    .next_pc (next_pc)
  );

  // State, PC and instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (retire) begin
          pc_d    = {next_pc[WIDTH-1:2], 2'b00};
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Datapath outputs are straight views of the registers.
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[OP_MSB:OP_LSB];
  assign funct     = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign pcplus4   = pc_q + WIDTH'(4);
  assign dbg_state = state_q;

`ifdef FETCH_PERFCNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count accepted retires and FETCH cycles spent waiting on memory.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (state_q == HOLD && retire) begin
      retired_cnt_d = retired_cnt_q + 32'd1;
    end
    if (state_q == FETCH && !imem_ack) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

  // Request and address stay put until the memory acknowledges.
  a_req_stable: assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  // The PC never leaves word alignment.
  a_pc_aligned: assert property (@(posedge clk) pc_q[1:0] == 2'b00);

endmodule
